// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port unified instruction/data memory.
// Serialises fetch reads and MEM-stage loads/stores, one access at a time,
// sequences the synchronous read latency and returns registered read data
// with one-cycle valid pulses. Data has priority, with an anti-starvation
// limit that eventually forces a pending fetch through.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          halt_f,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wrdata,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_rddata
);

    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT
    } state_t;

    state_t          state_q;
    logic            ownerData_q;
    logic            we_q;
    logic            cancel_q;
    logic [LW-1:0]   latCnt_q;
    logic [SW-1:0]   starveCnt_q;
    logic [SW-1:0]   starveCnt_d;
    logic [AW-1:0]   memAddr_q;
    logic [DW-1:0]   memWrdata_q;
    logic            memWren_q;
    logic [DW-1:0]   ifRdata_q;
    logic [DW-1:0]   dRdata_q;
    logic            ifValid_q;
    logic            dValid_q;

    logic            fetchEligible;
    logic            dataEligible;
    logic            starved;
    logic            inIdle;
    logic            grantFetch;
    logic            grantData;
    logic            lastWait;
    logic            fetchKilled;

    // A requester whose result is being returned this cycle is dropping its
    // request, so it must not be granted again; a flush blocks fetch grants.
    assign fetchEligible = if_req & ~if_flush & ~ifValid_q;
    assign dataEligible  = d_req & ~dValid_q;
    assign starved       = (starveCnt_q == SW'(STARVE_MAX));
    assign inIdle        = (state_q == S_IDLE);
    assign grantFetch    = inIdle & fetchEligible & (~dataEligible | starved);
    assign grantData     = inIdle & dataEligible & ~grantFetch;
    assign lastWait      = (latCnt_q == LW'(1));
    assign fetchKilled   = cancel_q | if_flush;

    // Counts consecutive data wins over an eligible fetch, saturating at the limit.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!if_req || grantFetch) begin
            starveCnt_d = '0;
        end else if (grantData && fetchEligible && !starved) begin
            starveCnt_d = starveCnt_q + SW'(1);
        end
    end

    // Access sequencer: grant in IDLE, one ACCESS cycle, then MEM_LAT WAIT cycles for reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ownerData_q <= 1'b0;
            we_q        <= 1'b0;
            cancel_q    <= 1'b0;
            latCnt_q    <= '0;
            starveCnt_q <= '0;
            memAddr_q   <= '0;
            memWrdata_q <= '0;
            memWren_q   <= 1'b0;
            ifRdata_q   <= '0;
            dRdata_q    <= '0;
            ifValid_q   <= 1'b0;
            dValid_q    <= 1'b0;
        end else begin
            starveCnt_q <= starveCnt_d;
            ifValid_q   <= 1'b0;
            dValid_q    <= 1'b0;
            memWren_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grantFetch) begin
                        ownerData_q <= 1'b0;
                        we_q        <= 1'b0;
                        cancel_q    <= 1'b0;
                        memAddr_q   <= if_addr;
                        memWrdata_q <= '0;
                        state_q     <= S_ACCESS;
                    end else if (grantData) begin
                        ownerData_q <= 1'b1;
                        we_q        <= d_we;
                        cancel_q    <= 1'b0;
                        memAddr_q   <= d_addr;
                        memWrdata_q <= d_wdata;
                        memWren_q   <= d_we;
                        state_q     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!ownerData_q && if_flush) begin
                        cancel_q <= 1'b1;
                    end
                    if (we_q) begin
                        dValid_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        latCnt_q <= LW'(MEM_LAT);
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!ownerData_q && if_flush) begin
                        cancel_q <= 1'b1;
                    end
                    latCnt_q <= latCnt_q - LW'(1);
                    if (lastWait) begin
                        state_q <= S_IDLE;
                        if (ownerData_q) begin
                            dRdata_q <= mem_rddata;
                            dValid_q <= 1'b1;
                        end else if (!fetchKilled) begin
                            ifRdata_q <= mem_rddata;
                            ifValid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = memAddr_q;
    assign mem_wrdata = memWrdata_q;
    assign mem_wren   = memWren_q;
    assign if_rdata   = ifRdata_q;
    assign if_valid   = ifValid_q;
    assign d_rdata    = dRdata_q;
    assign d_valid    = dValid_q;
    assign halt_f     = if_req & ~ifValid_q;
    assign d_stall    = d_req & ~dValid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// requester traffic, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MEM_LAT    = 1;
    localparam int STARVE_MAX = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          halt_f;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wrdata;
    logic          mem_wren;
    logic [DW-1:0] mem_rddata;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .halt_f(halt_f),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren),
        .mem_rddata(mem_rddata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int i);
        if (i == 16) return 32'h3000_0005;
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    // Synchronous single-port memory with one cycle of read latency.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rdQ;
    logic          memInit;
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= initWord(i);
        end else if (mem_wren) begin
            mem[mem_addr[7:0]] <= mem_wrdata;
        end
        rdQ <= mem[mem_addr[7:0]];
    end
    assign mem_rddata = rdQ;

    // Reference model state: the one outstanding transaction and when it ends.
    logic [31:0] modelMem [0:255];
    int          cyc;
    int          busyUntil;
    bit          haveTx, txFetch, txWe, txCancel;
    logic [31:0] txAddr, txWdata;
    int          txGrant, txDone;
    int          starve;
    logic        expIfValid, expDValid, expMemWren;
    logic [31:0] expIfRdata, expDRdata, expMemAddr, expMemWrdata;

    int nVec = 0;
    int nMis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        haveTx     = 0;
        txCancel   = 0;
        busyUntil  = cyc;
        starve     = 0;
        expIfValid = 0;
        expDValid  = 0;
        expMemWren = 0;
        expIfRdata = '0;
        expDRdata  = '0;
        expMemAddr = '0;
        expMemWrdata = '0;
    endtask

    task automatic checkOutput();
        chk("if_valid", if_valid, expIfValid);
        chk("d_valid", d_valid, expDValid);
        chk("mem_wren", mem_wren, expMemWren);
        chk("mem_addr", mem_addr, expMemAddr);
        chk("if_rdata", if_rdata, expIfRdata);
        chk("d_rdata", d_rdata, expDRdata);
        if (expMemWren) chk("mem_wrdata", mem_wrdata, expMemWrdata);
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic ifl,
                                 input logic dr, input logic dwe, input logic [31:0] da,
                                 input logic [31:0] dwd);
        if_req   = ir;
        if_addr  = ia;
        if_flush = ifl;
        d_req    = dr;
        d_we     = dwe;
        d_addr   = da;
        d_wdata  = dwd;
        #1;
        chk("halt_f", halt_f, ir & ~expIfValid);
        chk("d_stall", d_stall, dr & ~expDValid);
    endtask

    // Advance one clock: decide the model's grant from the applied inputs,
    // then predict and check the registered outputs of the next cycle.
    task automatic tick();
        bit fe, de, gf, gd;
        if (haveTx && txFetch && cyc > txGrant && cyc < txDone && if_flush) txCancel = 1;
        if (haveTx && txWe && cyc == txGrant + 1) modelMem[txAddr[7:0]] = txWdata;
        fe = if_req && !if_flush && !expIfValid;
        de = d_req && !expDValid;
        gf = 0;
        gd = 0;
        if (cyc >= busyUntil) begin
            if (fe && (!de || starve == STARVE_MAX)) gf = 1;
            else if (de) gd = 1;
        end
        if (!if_req || gf) starve = 0;
        else if (gd && fe && starve < STARVE_MAX) starve++;
        if (gf || gd) begin
            haveTx    = 1;
            txFetch   = gf;
            txWe      = gd && d_we;
            txAddr    = gf ? if_addr : d_addr;
            txWdata   = d_wdata;
            txGrant   = cyc;
            txCancel  = 0;
            txDone    = cyc + (txWe ? 2 : MEM_LAT + 2);
            busyUntil = txDone;
            expMemAddr = txAddr;
            if (txWe) expMemWrdata = d_wdata;
        end
        @(posedge clk);
        #1;
        cyc++;
        expMemWren = haveTx && txWe && cyc == txGrant + 1;
        expIfValid = haveTx && txFetch && !txCancel && cyc == txDone;
        expDValid  = haveTx && !txFetch && cyc == txDone;
        if (expIfValid) expIfRdata = modelMem[txAddr[7:0]];
        if (expDValid && !txWe) expDRdata = modelMem[txAddr[7:0]];
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    // Directed scenarios, then randomized traffic, in one linear sequence.
    initial begin
        logic        ir, ifl, dr, dwe, iflPrev;
        logic [31:0] ia, da, dwd;
        bit          fetchInFlight, dataInFlight;

        cyc = 0;
        for (int i = 0; i < 256; i++) modelMem[i] = initWord(i);
        rst = 1'b1;
        memInit = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        memInit = 1'b0;
        @(negedge clk);
        modelReset();
        checkOutput();
        rst = 1'b0;
        $display("[TB] reset released");

        // Fetch alone
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
        tick();
        chk("fetch_addr_c1", mem_addr, 32'h10);
        for (int c = 1; c < 3; c++) begin
            applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
            tick();
        end
        chk("fetch_valid_c3", if_valid, 1'b1);
        chk("fetch_data_c3", if_rdata, 32'h3000_0005);
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
        chk("fetch_halt_c3", halt_f, 1'b0);
        tick();
        idleCycles(2);

        // Collision: store wins, fetch follows
        applyStimulus(1, 32'h10, 0, 1, 1, 32'h40, 32'hDEAD_BEEF);
        tick();
        chk("coll_wren_c1", mem_wren, 1'b1);
        applyStimulus(1, 32'h10, 0, 1, 1, 32'h40, 32'hDEAD_BEEF);
        tick();
        chk("coll_dvalid_c2", d_valid, 1'b1);
        chk("coll_wren_c2", mem_wren, 1'b0);
        applyStimulus(1, 32'h10, 0, 1, 1, 32'h40, 32'hDEAD_BEEF);
        tick();
        chk("coll_fetch_addr_c3", mem_addr, 32'h10);
        chk("coll_mem40", mem[8'h40], 32'hDEAD_BEEF);
        for (int c = 3; c < 5; c++) begin
            applyStimulus(1, 32'h10, 0, 0, 0, 0, 0);
            tick();
        end
        chk("coll_ifvalid_c5", if_valid, 1'b1);
        idleCycles(2);

        // Flush of an in-flight fetch, then redirect
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 32'h20, (c == 2), 0, 0, 0, 0);
            tick();
        end
        chk("flush_noval_c3", if_valid, 1'b0);
        for (int c = 3; c < 6; c++) begin
            applyStimulus(1, 32'h08, 0, 0, 0, 0, 0);
            tick();
            if (c == 3) chk("flush_redirect_addr", mem_addr, 32'h08);
        end
        chk("flush_ifvalid_c6", if_valid, 1'b1);
        chk("flush_data_c6", if_rdata, initWord(8));
        idleCycles(2);

        // Starvation: two data grants, then fetch is forced, then data resumes
        for (int c = 0; c < 13; c++) begin
            if (c == 1) chk("starve_d1", mem_addr, 32'h41);
            if (c == 5) chk("starve_d2", mem_addr, 32'h42);
            if (c == 9) chk("starve_fetch", mem_addr, 32'h30);
            if (c == 12) chk("starve_d3", mem_addr, 32'h43);
            applyStimulus((c < 11), 32'h30, (c == 3 || c == 7), 1, 0,
                          (c < 3) ? 32'h41 : (c < 7) ? 32'h42 : 32'h43, 0);
            tick();
        end
        idleCycles(4);

        // Reset in the middle of a store
        applyStimulus(0, 0, 0, 1, 1, 32'h50, 32'hCAFE_F00D);
        tick();
        chk("rst_wren_before", mem_wren, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_wren_async", mem_wren, 1'b0);
        chk("rst_dstall", d_stall, 1'b1);
        chk("rst_haltf", halt_f, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_no_dvalid", d_valid, 1'b0);
        chk("rst_mem_unwritten", mem[8'h50], initWord(32'h50));
        @(negedge clk);
        modelReset();
        checkOutput();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 0, 0, (c < 2), 1, 32'h50, 32'hCAFE_F00D);
            tick();
        end
        chk("rst_regrant_mem", mem[8'h50], 32'hCAFE_F00D);
        idleCycles(2);

        // Randomized traffic from well-behaved requesters
        ir = 0; ia = 0; ifl = 0; iflPrev = 0; dr = 0; dwe = 0; da = 0; dwd = 0;
        for (int n = 0; n < 3000; n++) begin
            fetchInFlight = haveTx && txFetch && cyc < txDone;
            dataInFlight  = haveTx && !txFetch && cyc < txDone;
            if (iflPrev) ia = 32'($urandom_range(0, 31));
            if (ir && expIfValid) begin
                ir = ($urandom_range(0, 1) == 0);
                ia = 32'($urandom_range(0, 31));
            end else if (!ir) begin
                ir = ($urandom_range(0, 2) == 0);
                ia = 32'($urandom_range(0, 31));
            end else if (fetchInFlight && $urandom_range(0, 1) == 0) begin
                ia = 32'($urandom_range(0, 31));
            end
            ifl = ($urandom_range(0, 9) == 0);
            if ((dr && expDValid) || !dr) begin
                dr  = (dr && expDValid) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 2) == 0);
                dwe = ($urandom_range(0, 1) == 0);
                da  = 32'($urandom_range(0, 31));
                dwd = $urandom;
            end else if (dataInFlight && $urandom_range(0, 1) == 0) begin
                da  = 32'($urandom_range(0, 31));
                dwd = $urandom;
            end
            applyStimulus(ir, ia, ifl, dr, dwe, da, dwd);
            iflPrev = ifl;
            tick();
        end
        idleCycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the fetch stage (instruction reads) and the MEM stage (loads and stores).
- Serialises accesses, one outstanding at a time, and sequences the synchronous memory read latency.
- Returns registered read data with a one-cycle valid pulse.
- Generates the fetch stall (halt_f) and the MEM-stage stall.
- Data has priority over fetch, with an anti-starvation limit; a fetch already in flight can be cancelled on a branch redirect.

Parameters:
- AW, 32, address width (word address).
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (must be >= 1).
- STARVE_MAX, 2, consecutive data grants allowed while fetch is pending before fetch is forced (must be >= 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch read request; held until if_valid or if_flush.
- if_addr  in  AW  fetch address.
- if_flush  in  1  branch redirect; cancels the in-flight or pending fetch.
- if_rdata  out  DW  fetched instruction.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- halt_f  out  1  fetch stall.
- d_req  in  1  MEM-stage request; held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data.
- d_valid  out  1  one-cycle pulse: load data valid or store complete.
- d_stall  out  1  MEM-stage stall.
- mem_addr  out  AW  memory address.
- mem_wrdata  out  DW  memory write data.
- mem_wren  out  1  memory write enable.
- mem_rddata  in  DW  memory read data; valid MEM_LAT cycles after the address is presented.

Behaviour:
- States: IDLE, ACCESS, WAIT.
  - WAIT has a latency counter of $clog2(MEM_LAT+1) bits.
  - A starvation counter of $clog2(STARVE_MAX+1) bits tracks consecutive data wins over a pending fetch.
- Grant happens only in IDLE, only for eligible requesters.
  - A requester whose valid is high in the current cycle is not eligible that cycle (prevents a re-grant of a request being dropped).
  - Fetch is not eligible while if_flush=1.
- Priority: data wins, unless the starvation counter equals STARVE_MAX and fetch is eligible; then fetch wins.
  - The counter increments when data wins while fetch is eligible.
  - It clears when fetch is granted or when if_req=0.
  - It saturates at STARVE_MAX.
- On grant (at the edge): latch requester id, addr, wdata and we; go to ACCESS.
- ACCESS (1 cycle):
  - mem_addr and mem_wrdata come from the latched registers.
  - mem_wren=1 only for a store.
  - Store: go to IDLE; d_valid=1 in the next cycle.
  - Read: load the counter with MEM_LAT and go to WAIT.
- WAIT:
  - mem_addr is held and mem_wren=0.
  - The counter decrements each cycle.
  - In the final WAIT cycle, capture mem_rddata into if_rdata or d_rdata, go to IDLE, and pulse the matching valid in the next cycle.
- Read latency: request seen in IDLE at cycle 0 → valid at cycle MEM_LAT+2. Store latency: d_valid at cycle 2.
- Flush:
  - if_flush=1 in any cycle from the fetch grant edge through the final WAIT cycle marks the access cancelled.
  - The memory timing still completes and the state still returns to IDLE on schedule.
  - if_valid is suppressed and if_rdata is not updated.
  - Flush in IDLE with no fetch in flight only blocks that cycle's fetch grant.
  - Flush never affects data accesses.
- Stalls (combinational): halt_f = if_req & ~if_valid; d_stall = d_req & ~d_valid.
- Reset (asynchronous, any state, including mid-store):
  - Registered state: state=IDLE, both counters=0.
  - Registered outputs: mem_addr=0, mem_wrdata=0, mem_wren=0 immediately, if_rdata=0, d_rdata=0, if_valid=0, d_valid=0.
  - Combinational outputs during reset: halt_f=if_req, d_stall=d_req.
  - An in-flight access is abandoned with no valid.
- Inputs are sampled only at grant. Changes to a granted requester's addr or wdata afterwards have no effect.

Test Plan (MEM_LAT=1, STARVE_MAX=2):
- Fetch alone: if_req=1, if_addr=0x10, mem[0x10]=0x30000005.
  - Cycle 1: mem_addr=0x10.
  - Cycle 3: if_valid=1, if_rdata=0x30000005.
  - halt_f=1 in cycles 0–2 and 0 in cycle 3.
- Collision: d_req (store, 0x40, 0xDEADBEEF) and if_req (0x10) both at cycle 0.
  - mem_wren=1 in cycle 1 only; d_valid in cycle 2; mem[0x40]=0xDEADBEEF.
  - Fetch granted in cycle 2; if_valid in cycle 5.
- Starvation: if_req held; d_req held with a new load address after each d_valid.
  - Data granted twice.
  - The third grant goes to fetch (mem_addr=if_addr), then data resumes.
- Flush: fetch 0x20 granted at cycle 0, if_flush=1 in cycle 2, new if_addr=0x08 from cycle 3.
  - No if_valid in cycle 3.
  - 0x08 granted in cycle 3; if_valid in cycle 6 with mem[0x08].
- Reset mid-store: rst asserted in cycle 1 while mem_wren=1.
  - mem_wren drops to 0 within the cycle; no d_valid.
  - After release, a held d_req is re-granted from IDLE.
